// File: rtl/centroid_pkg.sv
// Shared types and helpers for the red-centroid tracker: FSM states, width
// helpers and the "cape red" pixel classifier.
package centroid_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_X   = 2'd1,
        DIV_Y   = 2'd2,
        PUBLISH = 2'd3
    } state_e;

    function automatic int unsigned coord_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Wide enough for a full frame of maximum-column red pixels.
    function automatic int unsigned sum_bits(input int unsigned w, input int unsigned h);
        return $clog2(w * h * w);
    endfunction

    // Zero-extended to 5 bits so the margin additions never overflow.
    function automatic logic is_red(input logic [11:0] pix,
                                    input logic [3:0]  r_min,
                                    input logic [3:0]  margin);
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        logic [4:0] rm;
        logic [4:0] m;
        r  = {1'b0, pix[11:8]};
        g  = {1'b0, pix[7:4]};
        b  = {1'b0, pix[3:0]};
        rm = {1'b0, r_min};
        m  = {1'b0, margin};
        return (r >= rm) && (r >= g + m) && (b + m <= r);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. A new start may be
// issued on the final iteration cycle so back-to-back divisions leave no gap.
module seq_divider #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_c_o,
    output logic [DIVIDEND_W-1:0] quotient_c_o
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quot_q, quot_d, quot_step;
    logic [DIVISOR_W-1:0]  rem_q, rem_d, rem_step;
    logic [DIVISOR_W-1:0]  dsor_q, dsor_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [DIVISOR_W:0]    partial;
    logic                  fits;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        partial   = {rem_q, quot_q[DIVIDEND_W-1]};
        fits      = partial >= {1'b0, dsor_q};
        rem_step  = fits ? (partial[DIVISOR_W-1:0] - dsor_q) : partial[DIVISOR_W-1:0];
        quot_step = {quot_q[DIVIDEND_W-2:0], fits};
    end

    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        dsor_d = dsor_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
            dsor_d = divisor_i;
            cnt_d  = CNT_W'(DIVIDEND_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quot_d = quot_step;
            rem_d  = rem_step;
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quot_q <= '0;
            rem_q  <= '0;
            dsor_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dsor_q <= dsor_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_c_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_c_o = quot_step;

endmodule

// File: rtl/red_centroid_tracker.sv
// Classifies filtered RGB444 pixels as red, emits the overlay stream and
// reports the per-frame red-region centroid via a shared serial divider.
module red_centroid_tracker
    import centroid_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240,
    parameter int unsigned PIXEL_BITS   = 12,
    parameter int unsigned ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int unsigned R_MIN        = 8,
    parameter int unsigned MARGIN       = 3,
    parameter int unsigned MIN_COUNT    = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [PIXEL_BITS-1:0]                 pixel_data,
    input  logic [ADDR_BITS-1:0]                  pixel_addr,
    output logic [PIXEL_BITS-1:0]                 overlay_data,
    output logic [ADDR_BITS-1:0]                  overlay_addr,
    output logic [coord_bits(IMAGE_WIDTH)-1:0]    centroid_x,
    output logic [coord_bits(IMAGE_HEIGHT)-1:0]   centroid_y,
    output logic [ADDR_BITS:0]                    red_count,
    output logic                                  target_found,
    output logic                                  centroid_valid,
    output logic                                  frame_dropped
);

    localparam int unsigned X_BITS   = coord_bits(IMAGE_WIDTH);
    localparam int unsigned Y_BITS   = coord_bits(IMAGE_HEIGHT);
    localparam int unsigned SUM_BITS = sum_bits(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int unsigned CNT_BITS = ADDR_BITS + 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

    state_e state_q, state_d;

    logic [X_BITS-1:0]     x_q, x_d, cur_x;
    logic [Y_BITS-1:0]     y_q, y_d, cur_y;
    logic [SUM_BITS-1:0]   sum_x_q, sum_x_d, acc_sx;
    logic [SUM_BITS-1:0]   sum_y_q, sum_y_d, acc_sy;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d, acc_cnt;
    logic [SUM_BITS-1:0]   snap_sx_q, snap_sy_q;
    logic [CNT_BITS-1:0]   snap_cnt_q;
    logic [X_BITS-1:0]     qx_q;
    logic [Y_BITS-1:0]     qy_q;

    logic [PIXEL_BITS-1:0] overlay_data_q, overlay_data_d;
    logic [ADDR_BITS-1:0]  overlay_addr_q;
    logic [X_BITS-1:0]     centroid_x_q;
    logic [Y_BITS-1:0]     centroid_y_q;
    logic [CNT_BITS-1:0]   red_count_q;
    logic                  target_found_q;
    logic                  centroid_valid_q;
    logic                  frame_dropped_q;

    logic                  frame_start, frame_end, red, found;
    logic                  snap_load, drop, publish, cap_x, cap_y;
    logic                  div_start, div_busy, div_done;
    logic [SUM_BITS-1:0]   div_dividend, div_quot;

    // Pixel path: coordinates, accumulation and overlay colour.
    always_comb begin
        frame_start    = (pixel_addr == '0);
        frame_end      = (pixel_addr == LAST_ADDR);
        red            = is_red(pixel_data, 4'(R_MIN), 4'(MARGIN));
        cur_x          = frame_start ? '0 : x_q;
        cur_y          = frame_start ? '0 : y_q;
        acc_sx         = (frame_start ? '0 : sum_x_q) + (red ? SUM_BITS'(cur_x) : '0);
        acc_sy         = (frame_start ? '0 : sum_y_q) + (red ? SUM_BITS'(cur_y) : '0);
        acc_cnt        = (frame_start ? '0 : cnt_q) + (red ? CNT_BITS'(1) : '0);
        x_d            = (cur_x == X_BITS'(IMAGE_WIDTH - 1)) ? '0 : cur_x + X_BITS'(1);
        y_d            = cur_y;
        if (cur_x == X_BITS'(IMAGE_WIDTH - 1)) begin
            y_d = (cur_y == Y_BITS'(IMAGE_HEIGHT - 1)) ? '0 : cur_y + Y_BITS'(1);
        end
        sum_x_d        = frame_end ? '0 : acc_sx;
        sum_y_d        = frame_end ? '0 : acc_sy;
        cnt_d          = frame_end ? '0 : acc_cnt;
        overlay_data_d = red ? {PIXEL_BITS{1'b1}} : pixel_data;
        found          = (snap_cnt_q >= CNT_BITS'(MIN_COUNT));
    end

    // Centroid FSM: X division, then Y division on the shared divider, then publish.
    always_comb begin
        state_d      = state_q;
        snap_load    = 1'b0;
        drop         = 1'b0;
        publish      = 1'b0;
        cap_x        = 1'b0;
        cap_y        = 1'b0;
        div_start    = 1'b0;
        div_dividend = snap_sx_q;
        if (frame_end) begin
            if (state_q == IDLE) snap_load = 1'b1;
            else                 drop      = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (frame_end) state_d = DIV_X;
            end
            DIV_X: begin
                if (!div_busy) begin
                    if (found) div_start = 1'b1;
                    else       state_d   = PUBLISH;
                end else if (div_done) begin
                    cap_x        = 1'b1;
                    div_start    = 1'b1;
                    div_dividend = snap_sy_q;
                    state_d      = DIV_Y;
                end
            end
            DIV_Y: begin
                if (div_done) begin
                    cap_y   = 1'b1;
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                publish = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    seq_divider #(
        .DIVIDEND_W (SUM_BITS),
        .DIVISOR_W  (CNT_BITS)
    ) u_div (
        .clk          (clk),
        .reset        (reset),
        .start_i      (div_start),
        .dividend_i   (div_dividend),
        .divisor_i    (snap_cnt_q),
        .busy_o       (div_busy),
        .done_c_o     (div_done),
        .quotient_c_o (div_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            x_q              <= '0;
            y_q              <= '0;
            sum_x_q          <= '0;
            sum_y_q          <= '0;
            cnt_q            <= '0;
            snap_sx_q        <= '0;
            snap_sy_q        <= '0;
            snap_cnt_q       <= '0;
            qx_q             <= '0;
            qy_q             <= '0;
            overlay_data_q   <= '0;
            overlay_addr_q   <= '0;
            centroid_x_q     <= '0;
            centroid_y_q     <= '0;
            red_count_q      <= '0;
            target_found_q   <= 1'b0;
            centroid_valid_q <= 1'b0;
            frame_dropped_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            x_q              <= x_d;
            y_q              <= y_d;
            sum_x_q          <= sum_x_d;
            sum_y_q          <= sum_y_d;
            cnt_q            <= cnt_d;
            overlay_data_q   <= overlay_data_d;
            overlay_addr_q   <= pixel_addr;
            centroid_valid_q <= publish;
            frame_dropped_q  <= drop;
            if (snap_load) begin
                snap_sx_q  <= acc_sx;
                snap_sy_q  <= acc_sy;
                snap_cnt_q <= acc_cnt;
            end
            // The centroid lies inside the frame, so narrowing loses nothing.
            if (cap_x) qx_q <= X_BITS'(div_quot);
            if (cap_y) qy_q <= Y_BITS'(div_quot);
            if (publish) begin
                red_count_q    <= snap_cnt_q;
                target_found_q <= found;
                if (found) begin
                    centroid_x_q <= qx_q;
                    centroid_y_q <= qy_q;
                end
            end
        end
    end

    assign overlay_data   = overlay_data_q;
    assign overlay_addr   = overlay_addr_q;
    assign centroid_x     = centroid_x_q;
    assign centroid_y     = centroid_y_q;
    assign red_count      = red_count_q;
    assign target_found   = target_found_q;
    assign centroid_valid = centroid_valid_q;
    assign frame_dropped  = frame_dropped_q;

endmodule

// File: tb/tb_red_centroid_tracker.sv
// Scoreboard bench for red_centroid_tracker on an 8x4 frame: the driver queues
// expected overlay/centroid/drop events, a negedge monitor checks them.
module tb_red_centroid_tracker;

    localparam int LAT_DIV  = 18;
    localparam int LAT_SKIP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] pixel_data = '0;
    logic [4:0]  pixel_addr = '0;
    logic [11:0] overlay_data;
    logic [4:0]  overlay_addr;
    logic [2:0]  centroid_x;
    logic [1:0]  centroid_y;
    logic [5:0]  red_count;
    logic        target_found;
    logic        centroid_valid;
    logic        frame_dropped;

    red_centroid_tracker #(
        .IMAGE_WIDTH  (8),
        .IMAGE_HEIGHT (4),
        .PIXEL_BITS   (12),
        .ADDR_BITS    (5),
        .R_MIN        (8),
        .MARGIN       (3),
        .MIN_COUNT    (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pixel_data     (pixel_data),
        .pixel_addr     (pixel_addr),
        .overlay_data   (overlay_data),
        .overlay_addr   (overlay_addr),
        .centroid_x     (centroid_x),
        .centroid_y     (centroid_y),
        .red_count      (red_count),
        .target_found   (target_found),
        .centroid_valid (centroid_valid),
        .frame_dropped  (frame_dropped)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int data; int addr; } ov_t;
    typedef struct { int cyc; int x; int y; int cnt; int found; } cen_t;

    ov_t         ovq[$];
    cen_t        cq[$];
    int          dq[$];
    int          rd_ov = 0;
    int          rd_c  = 0;
    int          rd_d  = 0;
    int          cyc = 0;
    logic        rst_smp = 1'b0;
    logic        fin = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [11:0] img [32];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= reset;
    end

    function automatic bit tb_red(input logic [11:0] p);
        int r, g, b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        return (r >= 8) && (g + 3 <= r) && (b + 3 <= r);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [11:0] d, input logic [4:0] a, input logic r);
        int ed;
        @(posedge clk);
        #1;
        reset      = r;
        pixel_data = d;
        pixel_addr = a;
        ed = r ? 0 : (tb_red(d) ? 'hFFF : int'(d));
        ovq.push_back('{cyc + 1, ed, r ? 0 : int'(a)});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(12'h000, 5'd1, 1'b0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 12'h000;
    endtask

    task automatic run_frame(input bit exp_cv, input int ex, input int ey,
                             input int ecnt, input int efound, input int lat);
        for (int a = 0; a < 32; a++) drive(img[a], 5'(a), 1'b0);
        if (exp_cv) cq.push_back('{cyc + 1 + lat, ex, ey, ecnt, efound});
    endtask

    // Monitor: the only process that compares and counts.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_smp) begin
                chk("rst_centroid_x", int'(centroid_x), 0);
                chk("rst_centroid_y", int'(centroid_y), 0);
                chk("rst_red_count", int'(red_count), 0);
                chk("rst_target_found", int'(target_found), 0);
                chk("rst_centroid_valid", int'(centroid_valid), 0);
                chk("rst_frame_dropped", int'(frame_dropped), 0);
            end
            if (rd_ov < ovq.size() && ovq[rd_ov].cyc == cyc) begin
                chk("overlay_data", int'(overlay_data), ovq[rd_ov].data);
                chk("overlay_addr", int'(overlay_addr), ovq[rd_ov].addr);
                rd_ov++;
            end
            if (rd_c < cq.size() && cq[rd_c].cyc < cyc) begin
                chk("centroid_valid_missing_cycle", cyc, cq[rd_c].cyc);
                rd_c++;
            end
            if (centroid_valid === 1'b1) begin
                chk("centroid_valid_expected", (rd_c < cq.size()) ? 1 : 0, 1);
                if (rd_c < cq.size()) begin
                    chk("centroid_valid_cycle", cyc, cq[rd_c].cyc);
                    chk("centroid_x", int'(centroid_x), cq[rd_c].x);
                    chk("centroid_y", int'(centroid_y), cq[rd_c].y);
                    chk("red_count", int'(red_count), cq[rd_c].cnt);
                    chk("target_found", int'(target_found), cq[rd_c].found);
                    rd_c++;
                end
            end
            if (rd_d < dq.size() && dq[rd_d] < cyc) begin
                chk("frame_dropped_missing_cycle", cyc, dq[rd_d]);
                rd_d++;
            end
            if (frame_dropped === 1'b1) begin
                chk("frame_dropped_expected", (rd_d < dq.size()) ? 1 : 0, 1);
                if (rd_d < dq.size()) begin
                    chk("frame_dropped_cycle", cyc, dq[rd_d]);
                    rd_d++;
                end
            end
            if (fin) begin
                chk("centroid_pending", cq.size() - rd_c, 0);
                chk("drop_pending", dq.size() - rd_d, 0);
                chk("overlay_pending", ovq.size() - rd_ov, 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // Stimulus: directed frames with hand-computed centroids.
    initial begin
        repeat (4) drive(12'h000, 5'd0, 1'b1);

        // Single red pixel at addr 19 -> (3,2), count 1.
        clear_img();
        img[19] = 12'hF00;
        run_frame(1'b1, 3, 2, 1, 1, LAT_DIV);
        idle(4);

        // Red at first and last addresses: sums (7,3)/2 -> (3,1).
        clear_img();
        img[0]  = 12'hF00;
        img[31] = 12'hF00;
        run_frame(1'b1, 3, 1, 2, 1, LAT_DIV);
        idle(4);

        // Boundary colours: 850 and 805 red, 860 and 700 not -> sums (9,1)/2.
        clear_img();
        img[5]  = 12'h850;
        img[6]  = 12'h860;
        img[7]  = 12'h700;
        img[12] = 12'h805;
        run_frame(1'b1, 4, 0, 2, 1, LAT_DIV);
        idle(4);

        // No red: centroid holds (4,0), count and found drop to 0.
        clear_img();
        run_frame(1'b1, 4, 0, 0, 0, LAT_SKIP);
        idle(4);

        // Partial frame with red at addr 3 is discarded by the restart at addr 0.
        for (int a = 0; a < 16; a++) drive((a == 3) ? 12'hF00 : 12'h000, 5'(a), 1'b0);
        clear_img();
        img[13] = 12'hF00;
        img[30] = 12'hF00;
        run_frame(1'b1, 5, 2, 2, 1, LAT_DIV);
        idle(4);

        // Second frame end while dividing: dropped, first result intact.
        clear_img();
        img[17] = 12'hF00;
        img[22] = 12'hF00;
        run_frame(1'b1, 3, 2, 2, 1, LAT_DIV);
        drive(12'h000, 5'd0, 1'b0);
        drive(12'hF00, 5'd31, 1'b0);
        dq.push_back(cyc + 1);
        idle(30);

        // Reset during division: no centroid_valid may follow.
        clear_img();
        img[19] = 12'hF00;
        run_frame(1'b0, 0, 0, 0, 0, 0);
        idle(3);
        repeat (3) drive(12'h000, 5'd1, 1'b1);
        idle(30);

        // Recovery after reset.
        run_frame(1'b1, 3, 2, 1, 1, LAT_DIV);
        idle(4);

        for (int i = 0; i < 200; i++) begin
            if (rd_c >= cq.size() && rd_d >= dq.size() && rd_ov >= ovq.size()) break;
            @(posedge clk);
        end
        fin = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
